autoconfig_multi: RTL and testbench
===================================

# autoconfig_multi

Parametrised Zorro III AutoConfig responder presenting `NUM_BOARDS` logical memory boards, one after another, on a single CFGIN_n/CFGOUT_n slot. It sits between the bus-interface glue and the RAM controller. It answers config-space reads with per-board nibbles and latches each board's base address. It then produces a one-hot RAM select from size-masked address comparison. It generalises the single-board 256 MB responder to 1–4 boards of 16 MB–256 MB each, with synchronous reset.

## Interface
Parameters:
- `NUM_BOARDS`, 2: logical boards, 1..4.
- `SIZE_LOG2`, {4{5'd26}}: packed 5 bits per board (board k at [5k+4:5k]), legal 24..28 (16 MB..256 MB).
- `PROD_ID`, {4{8'h72}}: packed 8 bits per board.
- `SERIAL`, 32'd421: board k reports SERIAL+k.

Ports:
- `CLK` in 1: system clock.
- `RESET` in 1: synchronous, active-high reset.
- `ADDRH` in 8: A31..A24.
- `CFG_IDX` in 7: nibble register index, decoded by top level.
- `CFG_SPACE` in 1: address lies in Z3 config space (A31..A16 = FF00).
- `FC` in 3: function code.
- `FCS_n`, `DS_n`, `READ` in 1 each: bus strobes and direction, already synchronous to CLK.
- `CFGIN_n` in 1: slot config-in.
- `DIN` in 8: D31..D24 on writes.
- `DOUT` out 4: read nibble.
- `DTACK` out 1: config cycle acknowledge.
- `CFGOUT_n` out 1: slot config-out.
- `AUTOCONFIG_CYCLE` out 1: current cycle is ours.
- `CONFIGURED` out NUM_BOARDS: per-board configured flag.
- `BASE` out 8·NUM_BOARDS: latched A31..A24 per board.
- `RAM_SEL` out NUM_BOARDS: one-hot board hit.

## Operation
- Validity: `validspace = FC[1]^FC[0]`, passed through a 2-flop synchroniser to give `vs`.
- `AUTOCONFIG_CYCLE` = CFG_SPACE & !CFGIN_n & CFGOUT_n & vs & (ptr < NUM_BOARDS).
- Board pointer `ptr` (3 bits) selects the board currently presented.
- FSM:
  - IDLE: go to START when !FCS_n & AUTOCONFIG_CYCLE.
  - START: go to IDLE if FCS_n; go to DATA if !DS_n.
  - DATA: one cycle; performs the read or write action, then goes to END.
  - END: DTACK=1; go to IDLE when FCS_n.
- Read nibbles for board ptr; unlisted indices read 4'hF. All IDs and serials are inverted.
  - 0x00: 4'b1010.
  - 0x01: {chain, SIZE_LOG2−24 as 3 bits}, where chain=1 unless ptr is the last board.
  - 0x02/0x03: ~PROD_ID[7:4] / ~PROD_ID[3:0].
  - 0x04: ~4'b1011.
  - 0x05: ~4'b0001.
  - 0x08–0x0B: ~16'h07DB, high nibble first.
  - 0x0C–0x13: ~(SERIAL+ptr), high nibble first.
  - 0x20/0x21: 4'h0.
- Writes:
  - idx 0x11: BASE[ptr] ← DIN and CONFIGURED[ptr] ← 1.
  - idx 0x13: shutup[ptr] ← 1.
  - Other writes are ignored.
- Advance: on the FCS_n rising edge (registered FCS_n was 0, now 1) that ends a cycle which configured or shut up the current board, ptr increments.
- CFGOUT_n:
  - Updates on the same edge.
  - Drops to 0 only once ptr reaches NUM_BOARDS.
  - Stays 0 until RESET.
- Address match: mask_k keeps the top (32−SIZE_LOG2_k) bits of A31..A24. hit_k = CONFIGURED[k] & !shutup[k] & vs & ((ADDRH^BASE_k)&mask_k)==0.
- RAM_SEL: one-hot, lowest-index hit wins on overlap. It is combinational from registered state and ADDRH.

## Timing
- Reset values:
  - FSM IDLE, ptr 0, DTACK 0, DOUT 4'h0.
  - CFGOUT_n 1, CONFIGURED 0, BASE all 8'hFF, shutup 0, vs 0.
- AUTOCONFIG_CYCLE and RAM_SEL are valid 2 CLK after FC settles, because of the synchroniser.
- DOUT is registered in DATA and is valid from END entry. DTACK rises 2 CLK after DS_n is sampled low, and falls on the first CLK with FCS_n high.
- FCS_n high in START aborts the cycle: no action, no DTACK.
- A write to 0x11 followed by 0x13 on the same board configures it and then is ignored, since ptr has already advanced.
- A board that is shut up never asserts RAM_SEL.
- RESET asserted mid-cycle returns everything to reset values on the next CLK. A DTACK in progress is dropped.
- While CFGIN_n is high, no config response is given, but RAM_SEL still functions.

## Structure
- Package `autoconfig_pkg` holds:
  - state encodings (IDLE/START/DATA/END);
  - register index localparams (0x11 base, 0x13 shutup);
  - MFG_ID 16'h07DB;
  - function `size_mask(log2)` returning the 8-bit mask.
- Sub-module `autoconfig_rom`: combinational nibble lookup (ptr, CFG_IDX, parameters → nibble). The top module registers its output in DATA.

## Test plan
- Board 0 reads, NUM_BOARDS=2, SIZE_LOG2 26/26: idx 0x00 → 4'hA; 0x01 → 4'hA (chain=1, code 2); 0x08 → ~0 = 4'hF; 0x0B → ~4'hB = 4'h4; DTACK pulses each cycle.
- Board 0 base write: write idx 0x11, DIN=8'h40 → CONFIGURED=01, CFGOUT_n still 1; board 1 then reads 0x01 → 4'h2 and serial 0x13 → ~(422&0xF) = 4'h9.
- Board 1 base write: write 8'h44 → CFGOUT_n falls after FCS_n rises. ADDRH 8'h43 → RAM_SEL=01; 8'h47 → 10; 8'h48 → 00.
- Shutup: shutup board 0, configure board 1 at 8'h80 → RAM_SEL never 01; ADDRH 8'h81 → 10; CFGOUT_n falls.
- Gating: FC=3'b111 → no DTACK, RAM_SEL=0. FC=3'b101 with CFGIN_n=1 → no DTACK.
- Resets: RESET during END → next CLK DTACK=0, ptr 0, CFGOUT_n 1. FCS_n high in START → no write takes effect.

Source files
------------

// File: rtl/autoconfig_pkg.sv
// Shared definitions for the multi-board Zorro III AutoConfig responder:
// FSM state encoding, writable register indices, manufacturer ID and the
// address-mask helper used for board decode.
package autoconfig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_END   = 2'd3
  } state_t;

  localparam logic [6:0]  IDX_BASE   = 7'h11;
  localparam logic [6:0]  IDX_SHUTUP = 7'h13;
  localparam logic [15:0] MFG_ID     = 16'h07DB;

  // Mask over A31..A24 that keeps the top (32 - log2) address bits,
  // e.g. 24 -> 8'hFF, 26 -> 8'hFC, 28 -> 8'hF0.
  function automatic logic [7:0] size_mask(input logic [4:0] log2);
    logic [4:0] sh;
    sh = log2 - 5'd24;
    return 8'hFF << sh[2:0];
  endfunction

endpackage

// File: rtl/autoconfig_rom.sv
// Combinational AutoConfig nibble lookup for the board selected by ptr.
// Ports:
//   ptr     - board currently presented on the slot
//   cfg_idx - nibble register index
//   nibble  - value returned to the bus (IDs and serial already inverted)
module autoconfig_rom
  import autoconfig_pkg::*;
#(
  parameter int          NUM_BOARDS = 2,
  parameter logic [19:0] SIZE_LOG2  = {4{5'd26}},
  parameter logic [31:0] PROD_ID    = {4{8'h72}},
  parameter logic [31:0] SERIAL     = 32'd421
) (
  input  logic [2:0] ptr,
  input  logic [6:0] cfg_idx,
  output logic [3:0] nibble
);

  localparam logic [2:0] LAST = 3'(NUM_BOARDS - 1);

  logic [1:0]  b;
  logic [4:0]  sl;
  logic [2:0]  sz_code;
  logic [7:0]  pid;
  logic [31:0] ser;
  logic        chain;

  // Only ptr values below NUM_BOARDS are ever presented, so two bits
  // select the per-board parameter slice.
  assign b       = ptr[1:0];
  assign sl      = SIZE_LOG2[5*b +: 5];
  assign sz_code = 3'(sl - 5'd24);
  assign pid     = PROD_ID[8*b +: 8];
  assign ser     = SERIAL + {29'd0, ptr};
  assign chain   = (ptr != LAST);

  always_comb begin
    nibble = 4'hF;
    case (cfg_idx)
      7'h00: nibble = 4'b1010;
      7'h01: nibble = {chain, sz_code};
      7'h02: nibble = ~pid[7:4];
      7'h03: nibble = ~pid[3:0];
      7'h04: nibble = ~4'b1011;
      7'h05: nibble = ~4'b0001;
      7'h08: nibble = ~MFG_ID[15:12];
      7'h09: nibble = ~MFG_ID[11:8];
      7'h0A: nibble = ~MFG_ID[7:4];
      7'h0B: nibble = ~MFG_ID[3:0];
      7'h0C: nibble = ~ser[31:28];
      7'h0D: nibble = ~ser[27:24];
      7'h0E: nibble = ~ser[23:20];
      7'h0F: nibble = ~ser[19:16];
      7'h10: nibble = ~ser[15:12];
      7'h11: nibble = ~ser[11:8];
      7'h12: nibble = ~ser[7:4];
      7'h13: nibble = ~ser[3:0];
      7'h20: nibble = 4'h0;
      7'h21: nibble = 4'h0;
      default: nibble = 4'hF;
    endcase
  end

endmodule

// File: rtl/autoconfig_multi.sv
// Zorro III AutoConfig responder presenting NUM_BOARDS logical memory boards
// one after another on a single CFGIN_n/CFGOUT_n slot, plus the one-hot RAM
// select decode for the configured boards.
// Ports:
//   CLK, RESET        - clock, synchronous active-high reset
//   ADDRH, CFG_IDX    - A31..A24 and decoded config nibble index
//   CFG_SPACE, FC     - config-space flag and function code
//   FCS_n, DS_n, READ - bus strobes and direction (synchronous to CLK)
//   CFGIN_n, CFGOUT_n - slot config chain
//   DIN, DOUT         - write byte D31..D24 / read nibble
//   DTACK             - config cycle acknowledge
//   AUTOCONFIG_CYCLE  - current bus cycle is addressed to this responder
//   CONFIGURED, BASE  - per-board configured flag and latched base
//   RAM_SEL           - one-hot board hit, lowest index wins
//
// state    | meaning
// ST_IDLE  | waiting for FCS_n with a cycle addressed to us
// ST_START | FCS_n low, waiting for DS_n (FCS_n high aborts)
// ST_DATA  | one cycle: latch read nibble or perform write
// ST_END   | DTACK asserted until FCS_n returns high
module autoconfig_multi
  import autoconfig_pkg::*;
#(
  parameter int          NUM_BOARDS = 2,
  parameter logic [19:0] SIZE_LOG2  = {4{5'd26}},
  parameter logic [31:0] PROD_ID    = {4{8'h72}},
  parameter logic [31:0] SERIAL     = 32'd421
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [7:0]              ADDRH,
  input  logic [6:0]              CFG_IDX,
  input  logic                    CFG_SPACE,
  input  logic [2:0]              FC,
  input  logic                    FCS_n,
  input  logic                    DS_n,
  input  logic                    READ,
  input  logic                    CFGIN_n,
  input  logic [7:0]              DIN,
  output logic [3:0]              DOUT,
  output logic                    DTACK,
  output logic                    CFGOUT_n,
  output logic                    AUTOCONFIG_CYCLE,
  output logic [NUM_BOARDS-1:0]   CONFIGURED,
  output logic [8*NUM_BOARDS-1:0] BASE,
  output logic [NUM_BOARDS-1:0]   RAM_SEL
);

  localparam logic [2:0] NB   = 3'(NUM_BOARDS);
  localparam logic [2:0] LAST = 3'(NUM_BOARDS - 1);

  state_t                state;
  logic [2:0]            ptr;
  logic                  fcs_q;
  logic                  cfgout_q;
  logic                  vs_meta, vs;
  logic [NUM_BOARDS-1:0] conf_q, shut_q, hit;
  logic [7:0]            base_q [NUM_BOARDS];
  logic [3:0]            rom_nib;
  logic                  ac, cur_done, advance;
  logic                  unused_fc2;

  assign unused_fc2 = FC[2];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      vs_meta <= 1'b0;
      vs      <= 1'b0;
    end else begin
      vs_meta <= FC[1] ^ FC[0];
      vs      <= vs_meta;
    end
  end

  assign ac = CFG_SPACE & ~CFGIN_n & cfgout_q & vs & (ptr < NB);

  always_comb begin
    cur_done = 1'b0;
    for (int k = 0; k < NUM_BOARDS; k++)
      if (ptr == 3'(k)) cur_done = conf_q[k] | shut_q[k];
  end

  // The pointer moves on only once the bus cycle that finished the current
  // board has fully ended, so the host sees the next board on its next cycle.
  assign advance = ~fcs_q & FCS_n & cur_done & (ptr < NB);

  autoconfig_rom #(
    .NUM_BOARDS(NUM_BOARDS),
    .SIZE_LOG2 (SIZE_LOG2),
    .PROD_ID   (PROD_ID),
    .SERIAL    (SERIAL)
  ) u_rom (
    .ptr    (ptr),
    .cfg_idx(CFG_IDX),
    .nibble (rom_nib)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= ST_IDLE;
      ptr      <= 3'd0;
      fcs_q    <= 1'b1;
      DTACK    <= 1'b0;
      DOUT     <= 4'h0;
      cfgout_q <= 1'b1;
      conf_q   <= '0;
      shut_q   <= '0;
      for (int k = 0; k < NUM_BOARDS; k++) base_q[k] <= 8'hFF;
    end else begin
      fcs_q <= FCS_n;
      if (advance) begin
        ptr <= ptr + 3'd1;
        if (ptr == LAST) cfgout_q <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (!FCS_n && ac) state <= ST_START;
        end
        ST_START: begin
          if (FCS_n)      state <= ST_IDLE;
          else if (!DS_n) state <= ST_DATA;
        end
        ST_DATA: begin
          DOUT <= rom_nib;
          if (!READ) begin
            for (int k = 0; k < NUM_BOARDS; k++) begin
              if (ptr == 3'(k)) begin
                if (CFG_IDX == IDX_BASE) begin
                  base_q[k] <= DIN;
                  conf_q[k] <= 1'b1;
                end
                if (CFG_IDX == IDX_SHUTUP) shut_q[k] <= 1'b1;
              end
            end
          end
          state <= ST_END;
        end
        ST_END: begin
          if (FCS_n) begin
            state <= ST_IDLE;
            DTACK <= 1'b0;
          end else begin
            DTACK <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_BOARDS; k++) begin : g_board
    localparam logic [7:0] MASK = size_mask(SIZE_LOG2[5*k +: 5]);
    assign BASE[8*k +: 8] = base_q[k];
    assign hit[k] = conf_q[k] & ~shut_q[k] & vs &
                    (((ADDRH ^ base_q[k]) & MASK) == 8'h00);
  end

  always_comb begin
    RAM_SEL = '0;
    for (int k = NUM_BOARDS - 1; k >= 0; k--)
      if (hit[k]) RAM_SEL = NUM_BOARDS'(1) << k;
  end

  assign CONFIGURED       = conf_q;
  assign CFGOUT_n         = cfgout_q;
  assign AUTOCONFIG_CYCLE = ac;

endmodule

// File: tb/tb_autoconfig_multi.sv
module tb_autoconfig_multi;
  localparam int          NB  = 2;
  localparam logic [19:0] SZL = {4{5'd26}};
  localparam logic [31:0] PID = {4{8'h72}};
  localparam logic [31:0] SER = 32'd421;
  localparam logic [15:0] MFG = 16'h07DB;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [7:0]    ADDRH;
  logic [6:0]    CFG_IDX;
  logic          CFG_SPACE;
  logic [2:0]    FC;
  logic          FCS_n, DS_n, READ, CFGIN_n;
  logic [7:0]    DIN;
  logic [3:0]    DOUT;
  logic          DTACK, CFGOUT_n, AUTOCONFIG_CYCLE;
  logic [NB-1:0] CONFIGURED, RAM_SEL;
  logic [8*NB-1:0] BASE;

  autoconfig_multi #(.NUM_BOARDS(NB), .SIZE_LOG2(SZL), .PROD_ID(PID), .SERIAL(SER)) dut (
    .CLK(CLK), .RESET(RESET), .ADDRH(ADDRH), .CFG_IDX(CFG_IDX), .CFG_SPACE(CFG_SPACE),
    .FC(FC), .FCS_n(FCS_n), .DS_n(DS_n), .READ(READ), .CFGIN_n(CFGIN_n), .DIN(DIN),
    .DOUT(DOUT), .DTACK(DTACK), .CFGOUT_n(CFGOUT_n), .AUTOCONFIG_CYCLE(AUTOCONFIG_CYCLE),
    .CONFIGURED(CONFIGURED), .BASE(BASE), .RAM_SEL(RAM_SEL)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_ptr;
  bit m_conf [NB];
  bit m_shut [NB];
  int m_base [NB];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_nib(input int p, input int idx);
    int sz;
    logic [31:0] s;
    logic [7:0] pd;
    sz = int'(SZL[5*p +: 5]);
    s  = SER + p;
    pd = PID[8*p +: 8];
    if (idx == 0) return 4'hA;
    if (idx == 1) return {(p != NB - 1), 3'(sz - 24)};
    if (idx == 2) return ~pd[7:4];
    if (idx == 3) return ~pd[3:0];
    if (idx == 4) return 4'h4;
    if (idx == 5) return 4'hE;
    if (idx >= 8 && idx <= 11) return ~4'(MFG >> (4 * (11 - idx)));
    if (idx >= 12 && idx <= 19) return ~4'(s >> (4 * (19 - idx)));
    if (idx == 32 || idx == 33) return 4'h0;
    return 4'hF;
  endfunction

  function automatic logic [NB-1:0] exp_sel(input int addr);
    int sh;
    if ((FC[1] ^ FC[0]) == 1'b0) return '0;
    for (int k = 0; k < NB; k++) begin
      sh = int'(SZL[5*k +: 5]) - 24;
      if (m_conf[k] && !m_shut[k] && ((addr >> sh) == (m_base[k] >> sh)))
        return NB'(1) << k;
    end
    return '0;
  endfunction

  function automatic logic [NB-1:0] m_conf_vec();
    logic [NB-1:0] v;
    for (int k = 0; k < NB; k++) v[k] = m_conf[k];
    return v;
  endfunction

  function automatic logic [8*NB-1:0] m_base_vec();
    logic [8*NB-1:0] v;
    for (int k = 0; k < NB; k++) v[8*k +: 8] = 8'(m_base[k]);
    return v;
  endfunction

  function automatic bit exp_ack();
    return (m_ptr < NB) && !CFGIN_n && CFG_SPACE && (FC[1] ^ FC[0]);
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    for (int k = 0; k < NB; k++) begin
      m_conf[k] = 0; m_shut[k] = 0; m_base[k] = 8'hFF;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK); RESET = 1'b1; FCS_n = 1'b1; DS_n = 1'b1; READ = 1'b1;
    @(negedge CLK); RESET = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
  endtask

  task automatic cyc(input logic [6:0] idx, input bit rd, input logic [7:0] din,
                     output logic [3:0] nib, output bit ack);
    @(negedge CLK);
    CFG_IDX = idx; READ = rd; DIN = din; FCS_n = 1'b0; DS_n = 1'b0;
    ack = 1'b0; nib = 4'hx;
    for (int i = 0; i < 12 && !ack; i++) begin
      @(negedge CLK);
      if (DTACK) begin ack = 1'b1; nib = DOUT; end
    end
    FCS_n = 1'b1; DS_n = 1'b1; READ = 1'b1;
    @(negedge CLK);
    check("dtack_release", DTACK, 0);
    @(negedge CLK);
  endtask

  task automatic rd(input logic [6:0] idx, input string tag, output logic [3:0] nib);
    bit ack, ea;
    ea = exp_ack();
    cyc(idx, 1'b1, 8'h00, nib, ack);
    check({tag, "_ack"}, ack, ea);
    if (ea) check(tag, nib, exp_nib(m_ptr, idx));
  endtask

  task automatic wr(input logic [6:0] idx, input logic [7:0] din, input string tag);
    bit ack, ea;
    logic [3:0] nib;
    ea = exp_ack();
    cyc(idx, 1'b0, din, nib, ack);
    check({tag, "_ack"}, ack, ea);
    if (ea) begin
      if (idx == 7'h11) begin m_base[m_ptr] = din; m_conf[m_ptr] = 1; m_ptr++; end
      else if (idx == 7'h13) begin m_shut[m_ptr] = 1; m_ptr++; end
    end
    check({tag, "_cfgout"}, CFGOUT_n, (m_ptr < NB));
    check({tag, "_conf"}, CONFIGURED, m_conf_vec());
    check({tag, "_base"}, BASE, m_base_vec());
  endtask

  task automatic sel(input logic [7:0] addr, input string tag);
    @(negedge CLK); ADDRH = addr;
    @(negedge CLK);
    check(tag, RAM_SEL, exp_sel(int'(addr)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] nib;
    bit ack;
    logic [7:0] b0, b1;

    RESET = 1'b1; ADDRH = 8'hFF; CFG_IDX = 7'h00; CFG_SPACE = 1'b1; FC = 3'b101;
    FCS_n = 1'b1; DS_n = 1'b1; READ = 1'b1; CFGIN_n = 1'b0; DIN = 8'h00;
    model_reset();
    repeat (3) @(negedge CLK);
    check("rst_dtack", DTACK, 0);
    check("rst_dout", DOUT, 0);
    check("rst_cfgout", CFGOUT_n, 1);
    check("rst_conf", CONFIGURED, 0);
    check("rst_base", BASE, {NB{8'hFF}});
    check("rst_sel", RAM_SEL, 0);
    @(negedge CLK); RESET = 1'b0;
    repeat (3) @(negedge CLK);

    // Board 0 identity
    rd(7'h00, "b0_idx00", nib); check("b0_idx00_const", nib, 4'hA);
    rd(7'h01, "b0_idx01", nib); check("b0_idx01_const", nib, 4'hA);
    rd(7'h08, "b0_idx08", nib); check("b0_idx08_const", nib, 4'hF);
    rd(7'h0B, "b0_idx0B", nib); check("b0_idx0B_const", nib, 4'h4);
    rd(7'h04, "b0_idx04", nib);
    rd(7'h20, "b0_idx20", nib);

    // Board 0 base, then board 1 identity
    wr(7'h11, 8'h40, "b0_base");
    check("b0_conf_const", CONFIGURED, 2'b01);
    rd(7'h01, "b1_idx01", nib); check("b1_idx01_const", nib, 4'h2);
    rd(7'h13, "b1_idx13", nib); check("b1_idx13_const", nib, 4'h9);

    // Abort in START: FCS_n returns high before DS_n falls
    @(negedge CLK); CFG_IDX = 7'h11; READ = 1'b0; DIN = 8'h55; FCS_n = 1'b0; DS_n = 1'b1;
    @(negedge CLK); FCS_n = 1'b1;
    @(negedge CLK); check("abort_dtack", DTACK, 0);
    @(negedge CLK); DS_n = 1'b0;
    repeat (3) @(negedge CLK);
    check("abort_dtack_late", DTACK, 0);
    DS_n = 1'b1; READ = 1'b1;
    check("abort_conf", CONFIGURED, 2'b01);
    check("abort_base", BASE, 16'hFF40);

    // Board 1 base: slot chain passes on
    wr(7'h11, 8'h44, "b1_base");
    check("b1_cfgout_const", CFGOUT_n, 0);
    sel(8'h43, "sel_43"); check("sel_43_const", RAM_SEL, 2'b01);
    sel(8'h47, "sel_47"); check("sel_47_const", RAM_SEL, 2'b10);
    sel(8'h48, "sel_48");
    CFGIN_n = 1'b1;
    sel(8'h47, "sel_cfgin_hi");
    CFGIN_n = 1'b0;
    rd(7'h00, "done_no_ack", nib);

    // Invalid function code gates decode
    @(negedge CLK); FC = 3'b111;
    repeat (3) @(negedge CLK);
    sel(8'h43, "sel_fc_bad"); check("sel_fc_bad_const", RAM_SEL, 0);
    FC = 3'b101;
    repeat (3) @(negedge CLK);

    // Shut up board 0, configure board 1
    do_reset();
    wr(7'h13, 8'h00, "b0_shut");
    wr(7'h11, 8'h80, "b1_base80");
    sel(8'h81, "shut_sel81"); check("shut_sel81_const", RAM_SEL, 2'b10);
    sel(8'hFF, "shut_selFF");
    check("shut_cfgout", CFGOUT_n, 0);

    // Gating of config responses
    do_reset();
    @(negedge CLK); FC = 3'b111;
    repeat (3) @(negedge CLK);
    cyc(7'h00, 1'b1, 8'h00, nib, ack); check("gate_fc_ack", ack, 0);
    FC = 3'b101; CFGIN_n = 1'b1;
    repeat (3) @(negedge CLK);
    cyc(7'h00, 1'b1, 8'h00, nib, ack); check("gate_cfgin_ack", ack, 0);
    CFGIN_n = 1'b0;
    repeat (2) @(negedge CLK);

    // Reset while DTACK is held in END
    wr(7'h11, 8'h40, "pre_rst_base");
    @(negedge CLK); CFG_IDX = 7'h00; READ = 1'b1; FCS_n = 1'b0; DS_n = 1'b0;
    ack = 1'b0;
    for (int i = 0; i < 12 && !ack; i++) begin
      @(negedge CLK);
      if (DTACK) ack = 1'b1;
    end
    check("pre_rst_ack", ack, 1);
    RESET = 1'b1;
    @(negedge CLK);
    check("midrst_dtack", DTACK, 0);
    check("midrst_cfgout", CFGOUT_n, 1);
    check("midrst_conf", CONFIGURED, 0);
    check("midrst_base", BASE, {NB{8'hFF}});
    RESET = 1'b0; FCS_n = 1'b1; DS_n = 1'b1;
    model_reset();
    repeat (3) @(negedge CLK);
    rd(7'h01, "midrst_ptr0", nib);

    // Randomized phase
    do_reset();
    for (int i = 0; i < 16; i++) rd(7'($urandom_range(0, 33)), "rnd_rd", nib);
    b0 = 8'($urandom_range(0, 255));
    b1 = 8'($urandom_range(0, 255));
    if ($urandom_range(0, 1) == 1) wr(7'h13, 8'h00, "rnd_shut0");
    else wr(7'h11, b0, "rnd_base0");
    for (int i = 0; i < 4; i++) rd(7'($urandom_range(0, 33)), "rnd_rd1", nib);
    wr(7'h11, b1, "rnd_base1");
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) sel(b0 ^ 8'($urandom_range(0, 7)), "rnd_sel_b0");
      else if (i % 3 == 1) sel(b1 ^ 8'($urandom_range(0, 7)), "rnd_sel_b1");
      else sel(8'($urandom_range(0, 255)), "rnd_sel");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
